sar_search_4bit: RTL and testbench

Successive-approximation search controller that drives the B operand of an external magnitude comparator and reads back its Eq/Gt/Sm flags. It recovers an unknown value A, applied to the comparator's other operand, within at most WIDTH compare cycles. It sits in the datapath wherever an unknown code must be digitised using only a compare primitive, such as threshold calibration or ADC-style search.

---
 rtl/sar_pkg.sv | 19 +
 rtl/sar_search_4bit_if.sv | 28 ++
 rtl/sar_search_4bit.sv | 105 ++++++++++
 tb/tb_sar_search_4bit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation search controller.
// Holds the FSM state encoding, the default search width and the MSB seed helper.
package sar_pkg;

    // Default width of the unknown value, trial guess and result.
    localparam int SAR_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } sar_state_t;

    // One-hot value with only the most significant bit of a width-bit word set.
    function automatic logic [31:0] msb_seed(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/sar_search_4bit_if.sv
// Handshake and comparator bundle for sar_search_4bit.
// master: the side that requests searches and owns the comparator flags.
// slave:  the search controller itself.
interface sar_search_4bit_if
    import sar_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH_DEF
);
    logic             start;
    logic             Eq;
    logic             Gt;
    logic             Sm;
    logic [WIDTH-1:0] guess;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             err;

    modport master (
        output start, Eq, Gt, Sm,
        input  guess, busy, done, result, err
    );

    modport slave (
        input  start, Eq, Gt, Sm,
        output guess, busy, done, result, err
    );
endinterface

// File: rtl/sar_search_4bit.sv
// Successive-approximation search controller.
// Drives a trial value onto an external magnitude comparator and narrows it one
// bit per cycle (MSB first) from the Eq/Gt/Sm flags, exiting early on Eq.
// Optional build macro SAR_ONEHOT_CHECK_EN: when defined, any flag pattern that
// is not exactly one-hot aborts the search with err=1 and result=0; when
// undefined, flags resolve by priority Eq > Gt > Sm (none asserted = Sm) and err
// stays 0.
module sar_search_4bit
    import sar_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH_DEF
) (
    input logic              clk,
    input logic              rst,
    sar_search_4bit_if.slave bus
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    sar_state_t       state;
    logic [IDX_W-1:0] idx;

    logic             keep_bit;
    logic             flag_fault;
    logic [WIDTH-1:0] adj_guess;
    logic [WIDTH-1:0] next_probe;

    // Resolve the comparator flags against the current guess and form the next trial.
    always_comb begin
        keep_bit   = bus.Gt && !bus.Eq;
        adj_guess  = bus.guess;
        adj_guess[idx] = keep_bit;
        next_probe = adj_guess | (WIDTH'(1) << (idx - 1'b1));
`ifdef SAR_ONEHOT_CHECK_EN
        flag_fault = !(({bus.Eq, bus.Gt, bus.Sm} == 3'b100) ||
                       ({bus.Eq, bus.Gt, bus.Sm} == 3'b010) ||
                       ({bus.Eq, bus.Gt, bus.Sm} == 3'b001));
`else
        flag_fault = 1'b0;
`endif
    end

    // Search FSM with registered guess, status and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= IDX_W'(WIDTH - 1);
            bus.guess  <= '0;
            bus.result <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        bus.guess <= WIDTH'(msb_seed(WIDTH));
                        idx       <= IDX_W'(WIDTH - 1);
                        bus.err   <= 1'b0;
                        bus.busy  <= 1'b1;
                        state     <= SEARCH;
                    end
                end

                SEARCH: begin
                    if (flag_fault) begin
                        // Ambiguous comparator answer: report it rather than guess.
                        bus.result <= '0;
                        bus.err    <= 1'b1;
                        bus.busy   <= 1'b0;
                        bus.done   <= 1'b1;
                        state      <= DONE;
                    end else if (bus.Eq) begin
                        bus.result <= bus.guess;
                        bus.busy   <= 1'b0;
                        bus.done   <= 1'b1;
                        state      <= DONE;
                    end else if (idx == '0) begin
                        bus.result <= adj_guess;
                        bus.busy   <= 1'b0;
                        bus.done   <= 1'b1;
                        state      <= DONE;
                    end else begin
                        bus.guess <= next_probe;
                        idx       <= idx - 1'b1;
                    end
                end

                DONE: begin
                    // Single-cycle done pulse; result and guess are left untouched.
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search_4bit.sv
// Self-checking bench for sar_search_4bit with a behavioural magnitude comparator.
// Honours SAR_ONEHOT_CHECK_EN for the flag-fault expectations.
module tb_sar_search_4bit;
    import sar_pkg::*;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sar_search_4bit_if #(.WIDTH(W)) bus ();

    sar_search_4bit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Comparator: A from the bench, B is the controller's guess; flags can be overridden.
    logic [W-1:0] a_val;
    logic         frc;
    logic         frc_eq, frc_gt, frc_sm;
    assign bus.Eq = frc ? frc_eq : (a_val == bus.guess);
    assign bus.Gt = frc ? frc_gt : (a_val >  bus.guess);
    assign bus.Sm = frc ? frc_sm : (a_val <  bus.guess);

    int vectors;
    int miscompares;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: with an honest comparator the search lands on A exactly. It exits
    // on Eq once the probe bit reaches A's lowest set bit, so the number of compare
    // cycles is WIDTH minus A's trailing-zero count (WIDTH when A is zero).
    function automatic int ref_cycles(input int a);
        int tz;
        if (a == 0) return W;
        tz = 0;
        while (((a >> tz) & 1) == 0) tz++;
        return W - tz;
    endfunction

    // One full search: pulse start, measure latency, check outputs and the pulse width.
    task automatic run_search(input string tag, input int a, input int exp_res,
                              input int exp_k, input int exp_err);
        int c;
        a_val = W'(a);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        c = 0;
        while (!bus.done && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        check({tag, ".latency"}, c, exp_k);
        check({tag, ".result"}, bus.result, exp_res);
        check({tag, ".err"}, bus.err, exp_err);
        @(posedge clk); #1;
        check({tag, ".done_width"}, bus.done, 0);
        check({tag, ".result_held"}, bus.result, exp_res);
    endtask

    typedef struct {
        int a;
        int exp_res;
        int exp_k;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int cnt;
        logic [5:0] mask;
        int g;

        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        frc = 1'b0; frc_eq = 1'b0; frc_gt = 1'b0; frc_sm = 1'b0;
        a_val = '0;

        tbl[0] = '{5, 5, 4};
        tbl[1] = '{8, 8, 1};
        tbl[2] = '{0, 0, 4};
        tbl[3] = '{15, 15, 4};
        tbl[4] = '{1, 1, 4};
        tbl[5] = '{6, 6, 3};
        tbl[6] = '{12, 12, 2};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst.guess", bus.guess, 0);
        check("rst.result", bus.result, 0);
        check("rst.busy", bus.busy, 0);
        check("rst.done", bus.done, 0);
        check("rst.err", bus.err, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle.busy", bus.busy, 0);

        // Directed table
        for (int i = 0; i < 7; i++)
            run_search($sformatf("tbl%0d_a%0d", i, tbl[i].a), tbl[i].a,
                       tbl[i].exp_res, tbl[i].exp_k, 0);

        // Guess trajectory for A=5: 8, 4, 6, 5 with busy high throughout
        a_val = 4'd5;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            g = (i == 0) ? 8 : (i == 1) ? 4 : (i == 2) ? 6 : 5;
            check($sformatf("traj5.guess%0d", i), bus.guess, g);
            check($sformatf("traj5.busy%0d", i), bus.busy, 1);
            @(posedge clk); #1;
        end
        check("traj5.done", bus.done, 1);
        check("traj5.result", bus.result, 5);
        @(posedge clk); #1;

        // Reset on the 2nd SEARCH cycle aborts without a done pulse
        a_val = 4'd11;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst.busy", bus.busy, 0);
        check("midrst.guess", bus.guess, 0);
        check("midrst.done", bus.done, 0);
        check("midrst.result", bus.result, 0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.done) cnt++;
        end
        check("midrst.no_done", cnt, 0);
        run_search("midrst.fresh", 11, 11, 4, 0);

        // start during SEARCH and during DONE is ignored
        a_val = 4'd6;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cnt = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (bus.done) cnt++;
            bus.start = (c == 1) || bus.done;
        end
        bus.start = 1'b0;
        check("ignore.done_count", cnt, 1);
        check("ignore.busy", bus.busy, 0);
        check("ignore.result", bus.result, 6);

        // start held high re-triggers on the cycle after done
        a_val = 4'd8;
        bus.start = 1'b1;
        @(posedge clk); #1;
        mask = '0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            mask[c] = bus.done;
        end
        bus.start = 1'b0;
        check("retrig.done_mask", mask, 6'b001001);
        cnt = 0;
        while (!bus.done && cnt < 10) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("retrig.drain", bus.done, 1);
        @(posedge clk); #1;

        // Gt and Sm both asserted on the 2nd compare cycle
        a_val = 4'd2;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        frc = 1'b1; frc_eq = 1'b0; frc_gt = 1'b1; frc_sm = 1'b1;
        @(posedge clk); #1;
        frc = 1'b0;
`ifdef SAR_ONEHOT_CHECK_EN
        check("fault.done", bus.done, 1);
        check("fault.err", bus.err, 1);
        check("fault.result", bus.result, 0);
`else
        check("fault.done_early", bus.done, 0);
        cnt = 0;
        while (!bus.done && cnt < 10) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("fault.latency_rest", cnt, 2);
        check("fault.err", bus.err, 0);
        check("fault.result", bus.result, 4);
`endif
        @(posedge clk); #1;

        // Randomized values against the reference model
        for (int i = 0; i < 40; i++) begin
            int a;
            a = int'($urandom_range(0, (1 << W) - 1));
            run_search($sformatf("rnd%0d_a%0d", i, a), a, a, ref_cycles(a), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
